uart_packet_tx: RTL and testbench

Parametrised UART packetizer that integrates the transmit FIFO, framing FSM, baud-tick generator and serial shifter in one block. Upstream logic pushes DATA_W-bit words with wr_en. The block frames each word as start, data LSB-first, optional parity, then 1 or 2 stop bits, and drives tx_out. It adds configurable width, depth, baud divider, parity mode, stop-bit count, back-to-back frames, a FIFO occupancy count and a dropped-write indication.

---
 rtl/uart_packet_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_packet_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// UART packetizer: FWFT transmit FIFO feeding a framing FSM that drives a
// start/data/parity/stop serial line at CLKS_PER_BIT clocks per bit.
module uart_packet_tx #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [DATA_W-1:0]               data_in,
  input  logic                            tx_ready,
  output logic                            tx_out,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            wr_drop,
  output logic                            tx_busy,
  output logic                            tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              push, pop, bit_end, last_stop;

  state_t            state;
  logic [BW-1:0]     baud_cnt;
  logic [IW-1:0]     bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shift_p0;
  logic              par_p0;

  assign bit_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
  assign push      = wr_en && !fifo_full;
  // A pop never frees a slot for a write in the same cycle: push uses the registered full flag.
  assign pop       = ((state == IDLE) || last_stop) && !fifo_empty && tx_ready;

  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)
      count_nxt = fifo_count + CW'(1);
    else if (pop && !push)
      count_nxt = fifo_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == CW'(FIFO_DEPTH));
      wr_drop    <= wr_en && fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Frame data: head word and its parity are captured at the pop edge
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_p0 <= mem[rd_ptr];
      par_p0   <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
    end else if ((state == DATA) && bit_end) begin
      shift_p0 <= shift_p0 >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
      case (state)
        IDLE: begin
          tx_out   <= 1'b1;
          tx_busy  <= 1'b0;
          baud_cnt <= '0;
          if (pop) begin
            state   <= START;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= shift_p0[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IW'(DATA_W - 1)) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                tx_out <= par_p0;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              tx_out  <= shift_p0[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx_out   <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          // Registered pulse: raise one cycle early so it lands on the final stop cycle
          if ((stop_idx == 1'(STOP_BITS - 1)) && (baud_cnt == BW'(CLKS_PER_BIT - 2)))
            tx_done <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              if (pop) begin
                state  <= START;
                tx_out <= 1'b0;
              end else begin
                state   <= IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: frame-timeline reference model with randomized
// traffic, plus a second instance with odd parity and two stop bits.
module tb_uart_packet_tx;

  localparam int DW    = 8;
  localparam int DEP   = 16;
  localparam int CPB   = 4;
  localparam int FLEN  = (1 + DW + 1 + 1) * CPB;
  localparam int FLEN2 = (1 + DW + 1 + 2) * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_ready = 1'b0;
  logic       tx_out, fifo_full, fifo_empty, wr_drop, tx_busy, tx_done;
  logic [4:0] fifo_count;

  logic       wr_en2 = 1'b0;
  logic [7:0] data_in2 = 8'h00;
  logic       tx_ready2 = 1'b1;
  logic       tx_out2, fifo_full2, fifo_empty2, wr_drop2, tx_busy2, tx_done2;
  logic [4:0] fifo_count2;

  uart_packet_tx #(.DATA_W(DW), .FIFO_DEPTH(DEP), .CLKS_PER_BIT(CPB),
                   .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .tx_ready(tx_ready),
    .tx_out(tx_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .wr_drop(wr_drop), .tx_busy(tx_busy), .tx_done(tx_done));

  uart_packet_tx #(.DATA_W(DW), .FIFO_DEPTH(DEP), .CLKS_PER_BIT(CPB),
                   .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .data_in(data_in2), .tx_ready(tx_ready2),
    .tx_out(tx_out2), .fifo_full(fifo_full2), .fifo_empty(fifo_empty2),
    .fifo_count(fifo_count2), .wr_drop(wr_drop2), .tx_busy(tx_busy2), .tx_done(tx_done2));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Serial bit k of a frame carrying word w: start, LSB-first data, parity, stops
  function automatic logic exp_bit(input logic [7:0] w, input int k, input int odd);
    logic p;
    p = (odd != 0);
    for (int i = 0; i < DW; i++) p = p ^ w[i];
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (k == DW + 1) return p;
    return 1'b1;
  endfunction

  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         t = 0;
  bit         mbusy = 1'b0, mlast, mpop;
  logic       e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_drop = 1'b0;
  logic       e_empty = 1'b1, e_full = 1'b0;
  int         e_cnt = 0;
  bit         chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mbusy  = 1'b0;
      t      = 0;
      e_drop = 1'b0;
    end else begin
      mlast  = mbusy && (t == FLEN - 1);
      mpop   = (!mbusy || mlast) && (mq.size() > 0) && tx_ready;
      e_drop = wr_en && (mq.size() == DEP);
      if (mpop) begin
        cur   = mq.pop_front();
        mbusy = 1'b1;
        t     = 0;
      end else if (mlast) begin
        mbusy = 1'b0;
      end else if (mbusy) begin
        t++;
      end
      if (wr_en && !e_drop) mq.push_back(data_in);
    end
    e_busy  = mbusy;
    e_done  = mbusy && (t == FLEN - 1);
    e_tx    = mbusy ? exp_bit(cur, t / CPB, 0) : 1'b1;
    e_cnt   = mq.size();
    e_empty = (e_cnt == 0);
    e_full  = (e_cnt == DEP);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tx_out", tx_out, e_tx);
      chk("tx_busy", tx_busy, e_busy);
      chk("tx_done", tx_done, e_done);
      chk("wr_drop", wr_drop, e_drop);
      chk("fifo_count", fifo_count, e_cnt);
      chk("fifo_empty", fifo_empty, e_empty);
      chk("fifo_full", fifo_full, e_full);
    end
  end

  int bc, dc, mx, c2;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_tx_out", tx_out, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    rst = 1'b0;
    tx_ready = 1'b1;

    // single 0xA5 frame
    bc = 0; dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bc += int'(tx_busy); dc += int'(tx_done);
      if (i == 2) chk("a5_start_low", tx_out, 0);
      wr_en = (i == 0); data_in = 8'hA5;
    end
    chk("a5_len", bc, FLEN);
    chk("a5_done", dc, 1);
    chk("a5_empty", fifo_empty, 1);

    // three back-to-back frames
    bc = 0; dc = 0; mx = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      bc += int'(tx_busy); dc += int'(tx_done);
      if (int'(fifo_count) > mx) mx = int'(fifo_count);
      wr_en = (i < 3); data_in = 8'(8'h11 * (i + 1));
    end
    chk("b2b_busy", bc, 3 * FLEN);
    chk("b2b_done", dc, 3);
    chk("b2b_peak", mx, 2);

    // fill with tx_ready low, overflow, then pop and write at full together
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("full16", fifo_full, 1);
        chk("cnt16", fifo_count, 16);
      end
      wr_en = 1'b1; data_in = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("drop17", wr_drop, 1);
    chk("cnt_after_drop", fifo_count, 16);
    chk("idle_while_held", tx_out, 1);
    @(negedge clk);
    chk("drop_one_cycle", wr_drop, 0);
    tx_ready = 1'b1; wr_en = 1'b1; data_in = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("drop_pop_same", wr_drop, 1);
    chk("cnt_pop_same", fifo_count, 15);
    repeat (16 * FLEN + 20) @(negedge clk);
    chk("drain_empty", fifo_empty, 1);

    // tx_ready drops mid-frame with two words queued
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      wr_en = (i < 3); data_in = 8'($urandom);
      if (i == 15) tx_ready = 1'b0;
    end
    chk("held_cnt", fifo_count, 2);
    chk("held_busy", tx_busy, 0);
    tx_ready = 1'b1;
    repeat (2 * FLEN + 10) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) tx_ready = ~tx_ready;
    end
    wr_en = 1'b0; tx_ready = 1'b1;
    repeat (17 * FLEN + 10) @(negedge clk);
    chk("rand_drained", fifo_empty, 1);

    // reset in the middle of a data bit with three words queued
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_en = (i < 4); data_in = 8'($urandom);
    end
    chk("prerst_cnt", fifo_count, 3);
    chk("prerst_busy", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", tx_out, 1);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_cnt", fifo_count, 0);
    chk("rst_mid_empty", fifo_empty, 1);
    rst = 1'b0;
    dc = 0;
    repeat (60) begin
      @(negedge clk);
      dc += int'(tx_done);
    end
    chk("rst_no_done", dc, 0);

    // odd parity, two stop bits, word 0x00
    c2 = 0; dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_busy2) begin
        chk("f2_bit", tx_out2, exp_bit(8'h00, c2 / CPB, 1));
        c2++;
      end
      dc += int'(tx_done2);
      wr_en2 = (i == 0); data_in2 = 8'h00;
    end
    chk("f2_len", c2, FLEN2);
    chk("f2_done", dc, 1);
    chk("f2_idle", tx_out2, 1);
    chk("f2_empty", fifo_empty2, 1);
    chk("f2_cnt", fifo_count2, 0);
    chk("f2_full", fifo_full2, 0);
    chk("f2_drop", wr_drop2, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
